// File: rtl/adi_spi_cmd_arbiter.sv
// rtl/adi_spi_cmd_arbiter.sv - two-requester round-robin command arbiter for a shared ADI SPI engine
module adi_spi_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int GAP_CYCLES     = 2
) (
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_rw,
   input  logic [6:0] req0_addr,
   input  logic [7:0] req0_wdata,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_rw,
   input  logic [6:0] req1_addr,
   input  logic [7:0] req1_wdata,
   output logic       rsp0_valid,
   output logic [7:0] rsp0_rdata,
   output logic       rsp0_err,
   output logic       rsp1_valid,
   output logic [7:0] rsp1_rdata,
   output logic       rsp1_err,
   output logic       eng_valid,
   input  logic       eng_ready,
   output logic       eng_rw,
   output logic [6:0] eng_addr,
   output logic [7:0] eng_wdata,
   input  logic       eng_done,
   input  logic [7:0] eng_rdata,
   output logic       busy,
   output logic [7:0] timeout_cnt
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, GAP} state_t;

   state_t      state_q, state_d;
   logic        grant_q, last_grant_q;
   logic        cmd_rw_q;
   logic [6:0]  cmd_addr_q;
   logic [7:0]  cmd_wdata_q;
   logic [15:0] wait_cnt_q;
   logic [3:0]  gap_cnt_q;
   logic [7:0]  rsp0_rdata_q, rsp1_rdata_q;
   logic        rsp0_err_q, rsp1_err_q;
   logic [7:0]  timeout_cnt_q;

   logic        any_valid, grant_sel, done_hit, timeout_hit;
   logic [7:0]  resp_rdata;

   // Ties go to whichever requester was not served last.
   assign any_valid   = req0_valid | req1_valid;
   assign grant_sel   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
   assign done_hit    = (state_q == WAIT_DONE) & eng_done;
   assign timeout_hit = (state_q == WAIT_DONE) & ~eng_done &
                        (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
   assign resp_rdata  = (done_hit & cmd_rw_q) ? eng_rdata : 8'h00;

   assign req0_ready  = (state_q == IDLE) & any_valid & ~grant_sel;
   assign req1_ready  = (state_q == IDLE) & any_valid & grant_sel;
   assign eng_valid   = (state_q == ISSUE);
   assign eng_rw      = cmd_rw_q;
   assign eng_addr    = cmd_addr_q;
   assign eng_wdata   = cmd_wdata_q;
   assign rsp0_valid  = (state_q == RESP) & ~grant_q;
   assign rsp1_valid  = (state_q == RESP) & grant_q;
   assign rsp0_rdata  = rsp0_rdata_q;
   assign rsp1_rdata  = rsp1_rdata_q;
   assign rsp0_err    = rsp0_err_q;
   assign rsp1_err    = rsp1_err_q;
   assign busy        = (state_q != IDLE);
   assign timeout_cnt = timeout_cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (any_valid) state_d = ISSUE;
         ISSUE:     if (eng_ready) state_d = WAIT_DONE;
         WAIT_DONE: if (done_hit || timeout_hit) state_d = RESP;
         RESP:      state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:       if (gap_cnt_q == 4'(GAP_CYCLES - 1)) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         cmd_rw_q      <= 1'b0;
         cmd_addr_q    <= 7'h00;
         cmd_wdata_q   <= 8'h00;
         wait_cnt_q    <= 16'h0000;
         gap_cnt_q     <= 4'h0;
         rsp0_rdata_q  <= 8'h00;
         rsp1_rdata_q  <= 8'h00;
         rsp0_err_q    <= 1'b0;
         rsp1_err_q    <= 1'b0;
         timeout_cnt_q <= 8'h00;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any_valid) begin
            grant_q      <= grant_sel;
            last_grant_q <= grant_sel;
            cmd_rw_q     <= grant_sel ? req1_rw    : req0_rw;
            cmd_addr_q   <= grant_sel ? req1_addr  : req0_addr;
            cmd_wdata_q  <= grant_sel ? req1_wdata : req0_wdata;
         end
         if (state_q == ISSUE) wait_cnt_q <= 16'h0000;
         else if (state_q == WAIT_DONE) wait_cnt_q <= wait_cnt_q + 16'd1;
         if (done_hit || timeout_hit) begin
            if (grant_q) begin
               rsp1_rdata_q <= resp_rdata;
               rsp1_err_q   <= timeout_hit;
            end else begin
               rsp0_rdata_q <= resp_rdata;
               rsp0_err_q   <= timeout_hit;
            end
         end
         if (timeout_hit && timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
         if (state_q == RESP) gap_cnt_q <= 4'h0;
         else if (state_q == GAP) gap_cnt_q <= gap_cnt_q + 4'd1;
      end
   end

endmodule

// File: tb/tb_adi_spi_cmd_arbiter.sv
// tb/tb_adi_spi_cmd_arbiter.sv - directed self-checking bench for adi_spi_cmd_arbiter
module tb_adi_spi_cmd_arbiter;

   logic       ACLK = 1'b0;
   logic       ARESETN;
   logic       req0_valid, req0_rw, req1_valid, req1_rw;
   logic [6:0] req0_addr, req1_addr;
   logic [7:0] req0_wdata, req1_wdata;
   logic       eng_ready, eng_done;
   logic [7:0] eng_rdata;

   logic       req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [7:0] rsp0_rdata, rsp1_rdata, eng_wdata, timeout_cnt;
   logic       eng_valid, eng_rw, busy;
   logic [6:0] eng_addr;

   logic       t_req0_ready, t_req1_ready, t_rsp0_valid, t_rsp0_err, t_rsp1_valid, t_rsp1_err;
   logic [7:0] t_rsp0_rdata, t_rsp1_rdata, t_eng_wdata, t_timeout_cnt;
   logic       t_eng_valid, t_eng_rw, t_busy;
   logic [6:0] t_eng_addr;

   int errors = 0;
   int checks = 0;

   always #5 ACLK = ~ACLK;

   adi_spi_cmd_arbiter dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_rw(eng_rw),
      .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_done(eng_done),
      .eng_rdata(eng_rdata), .busy(busy), .timeout_cnt(timeout_cnt)
   );

   adi_spi_cmd_arbiter #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(2)) dut_t (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req0_valid(req0_valid), .req0_ready(t_req0_ready), .req0_rw(req0_rw),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(t_req1_ready), .req1_rw(req1_rw),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(t_rsp0_valid), .rsp0_rdata(t_rsp0_rdata), .rsp0_err(t_rsp0_err),
      .rsp1_valid(t_rsp1_valid), .rsp1_rdata(t_rsp1_rdata), .rsp1_err(t_rsp1_err),
      .eng_valid(t_eng_valid), .eng_ready(eng_ready), .eng_rw(t_eng_rw),
      .eng_addr(t_eng_addr), .eng_wdata(t_eng_wdata), .eng_done(eng_done),
      .eng_rdata(eng_rdata), .busy(t_busy), .timeout_cnt(t_timeout_cnt)
   );

   typedef struct {
      logic       id;
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
      int         rdy_dly;
      int         done_dly;
      logic       hs_done;
      logic [7:0] eng_rd;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic zero_inputs();
      req0_valid = 0; req0_rw = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 0; req1_rw = 0; req1_addr = 0; req1_wdata = 0;
      eng_ready = 0; eng_done = 0; eng_rdata = 0;
   endtask

   task automatic do_reset();
      ARESETN = 0;
      zero_inputs();
      @(posedge ACLK);
      @(posedge ACLK);
      #1;
      ARESETN = 1;
   endtask

   task automatic do_txn(input vec_t v);
      logic early, stable;
      early = 0;
      stable = 1;
      step();
      if (v.id) begin
         req1_valid = 1; req1_rw = v.rw; req1_addr = v.addr; req1_wdata = v.wdata;
      end else begin
         req0_valid = 1; req0_rw = v.rw; req0_addr = v.addr; req0_wdata = v.wdata;
      end
      #1;
      chk("grant_ready", v.id ? req1_ready : req0_ready, 1);
      chk("other_ready", v.id ? req0_ready : req1_ready, 0);
      step();
      req0_valid = 0; req1_valid = 0;
      eng_ready = (v.rdy_dly == 0);
      eng_done = v.hs_done & eng_ready;
      eng_rdata = 8'h11;
      #1;
      chk("eng_valid", eng_valid, 1);
      chk("eng_rw", eng_rw, v.rw);
      chk("eng_addr", eng_addr, v.addr);
      chk("eng_wdata", eng_wdata, v.wdata);
      for (int k = 1; k <= v.rdy_dly; k++) begin
         step();
         eng_ready = (k == v.rdy_dly);
         eng_done = v.hs_done & eng_ready;
         #1;
         if (!(eng_valid && eng_rw == v.rw && eng_addr == v.addr && eng_wdata == v.wdata)) stable = 0;
      end
      if (v.rdy_dly > 0) chk("eng_stable", stable, 1);
      for (int d = 1; d <= v.done_dly; d++) begin
         step();
         eng_ready = 0;
         eng_done = (d == v.done_dly);
         eng_rdata = (d == v.done_dly) ? v.eng_rd : 8'hC3;
         #1;
         if (rsp0_valid || rsp1_valid || eng_valid) early = 1;
      end
      chk("no_early_rsp", early, 0);
      step();
      eng_done = 0;
      #1;
      chk("rsp_valid", v.id ? rsp1_valid : rsp0_valid, 1);
      chk("rsp_other", v.id ? rsp0_valid : rsp1_valid, 0);
      chk("rsp_rdata", v.id ? rsp1_rdata : rsp0_rdata, v.exp_rd);
      chk("rsp_err", v.id ? rsp1_err : rsp0_err, 0);
      step();
      #1;
      chk("rsp_pulse", rsp0_valid | rsp1_valid, 0);
      chk("rdata_hold", v.id ? rsp1_rdata : rsp0_rdata, v.exp_rd);
      chk("busy_gap", busy, 1);
      step();
   endtask

   initial begin
      int grants, rsps, last_rsp, hs_c, rsp_c, n;
      logic hs, both_rdy, last_g;

      vecs[0] = '{1'b0, 1'b0, 7'h15, 8'hA5, 0, 20, 1'b0, 8'hEE, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 7'h37, 8'h00, 0, 3, 1'b0, 8'h5C, 8'h5C};
      vecs[2] = '{1'b0, 1'b1, 7'h7F, 8'h12, 2, 1, 1'b0, 8'h81, 8'h81};
      vecs[3] = '{1'b1, 1'b0, 7'h00, 8'hFF, 1, 5, 1'b0, 8'h33, 8'h00};
      vecs[4] = '{1'b1, 1'b1, 7'h4C, 8'h00, 0, 3, 1'b1, 8'hD2, 8'hD2};
      vecs[5] = '{1'b0, 1'b1, 7'h2A, 8'h00, 50, 2, 1'b0, 8'h3C, 8'h3C};

      ARESETN = 0;
      zero_inputs();
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_eng_valid", eng_valid, 0);
      chk("rst_eng_fields", {eng_rw, eng_addr, eng_wdata}, 0);
      chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata}, 0);
      chk("rst_timeout_cnt", timeout_cnt, 0);
      do_reset();

      foreach (vecs[i]) do_txn(vecs[i]);
      chk("no_timeouts", timeout_cnt, 0);

      // Both requesters pending continuously: grants alternate with a 3-cycle rsp-to-ready spacing.
      do_reset();
      req0_valid = 1; req0_rw = 0; req0_addr = 7'h01; req0_wdata = 8'h01;
      req1_valid = 1; req1_rw = 1; req1_addr = 7'h02;
      eng_ready = 1;
      grants = 0; rsps = 0; last_rsp = -1; hs = 0; both_rdy = 0; last_g = 0;
      for (int c = 0; c < 200 && rsps < 4; c++) begin
         #1;
         if (req0_ready && req1_ready) both_rdy = 1;
         if (req0_ready || req1_ready) begin
            chk("rr_grant", req1_ready, grants % 2);
            if (last_rsp >= 0) chk("rr_gap_len", c - last_rsp, 3);
            last_g = req1_ready;
            grants++;
         end
         if (eng_valid) hs = 1;
         if (rsp0_valid || rsp1_valid) begin
            chk("rr_rsp_id", rsp1_valid, last_g);
            last_rsp = c;
            rsps++;
         end
         step();
         eng_done = hs;
         hs = 0;
         if (grants >= 4) begin
            req0_valid = 0; req1_valid = 0;
         end
      end
      chk("rr_rsp_count", rsps, 4);
      chk("rr_both_ready", both_rdy, 0);

      // Reset during WAIT_DONE aborts silently and ignores a late completion.
      do_reset();
      req0_valid = 1; req0_rw = 1; req0_addr = 7'h22;
      step();
      step();
      req0_valid = 0; eng_ready = 1;
      step();
      eng_ready = 0;
      step();
      step();
      #1;
      chk("mid_busy", busy, 1);
      ARESETN = 0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_outputs", {eng_valid, rsp0_valid, rsp1_valid, eng_addr}, 0);
      step();
      ARESETN = 1;
      step();
      eng_done = 1; eng_rdata = 8'h99;
      #1;
      chk("late_done_rsp", rsp0_valid, 0);
      step();
      eng_done = 0;
      #1;
      chk("late_done_idle", {busy, rsp0_valid, rsp0_rdata}, 0);
      do_txn('{1'b0, 1'b1, 7'h22, 8'h00, 0, 4, 1'b0, 8'h6E, 8'h6E});

      // Timeout path on the TIMEOUT_CYCLES=8 instance.
      do_reset();
      eng_ready = 1; eng_rdata = 8'hAB;
      req0_valid = 1; req0_rw = 1; req0_addr = 7'h11;
      hs_c = -1; rsp_c = -1;
      for (int c = 0; c < 40 && rsp_c < 0; c++) begin
         #1;
         if (t_eng_valid && hs_c < 0) hs_c = c;
         if (t_rsp0_valid) begin
            rsp_c = c;
            chk("to_err", t_rsp0_err, 1);
            chk("to_rdata", t_rsp0_rdata, 0);
            chk("to_cnt_one", t_timeout_cnt, 1);
         end
         step();
      end
      chk("to_latency", rsp_c - hs_c, 9);
      n = 1;
      for (int c = 0; c < 256 * 16 && n < 257; c++) begin
         #1;
         if (t_rsp0_valid) begin
            n++;
            if (n == 255) chk("to_cnt_255", t_timeout_cnt, 255);
         end
         step();
      end
      chk("to_total", n, 257);
      chk("to_cnt_sat", t_timeout_cnt, 255);
      req0_valid = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
